uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Full-duplex 8-bit UART: shared baud-tick generator, serial transmitter and oversampling receiver in one block, on the single system clock.
- Receiver status is reported in a line-status register (LSR), modelled on the 16550 register of that name.
- Sits between a host byte interface (with an external RX FIFO full flag) and the serial pins.
- Bench loops tx back to rx externally.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- OVERSAMPLE, 16, baud ticks per serial bit.
- TICK_DIV, round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)) = 326, clocks per baud tick (derived localparam).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- tx_start  in  1  one-cycle request to send data_in.
- data_in  in  8  byte to transmit, captured when tx_start is accepted.
- tx  out  1  serial output, idle high.
- tx_done_tick  out  1  one-cycle pulse at end of stop bit.
- tx_busy  out  1  high while a frame is being sent.
- rx  in  1  serial input, asynchronous.
- fifo_full  in  1  downstream RX FIFO full; blocks data_out update.
- clear_flags  in  1  one-cycle pulse clearing LSR[2:0].
- data_out  out  8  last received byte.
- LSR  out  8  [0] data available, [1] overrun, [2] parity error, [3] no framing error (stop bit was 1), [7:4] read as 0.
- b_tick  out  1  baud tick, exported for debug.

Behaviour:
- Reset values (asynchronous, while reset=0): tx=1, tx_done_tick=0, tx_busy=0, data_out=0, LSR=8'h08, all counters 0, both FSMs IDLE.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1.
  - b_tick=1 for exactly one clock when the counter wraps to 0.
- TX FSM IDLE->START->DATA->PARITY->STOP->IDLE:
  - tx_start is accepted only in IDLE; ignored while busy. Acceptance latches data_in.
  - Each state lasts OVERSAMPLE ticks. START drives 0; DATA sends bits LSB first; PARITY sends even parity (XOR of the data bits); STOP drives 1.
  - tx_done_tick pulses one clock on the tick that ends STOP, then IDLE.
  - tx_busy=1 from the accept cycle until return to IDLE.
- RX input: rx passes through a 2-flop synchronizer (2-clock latency).
- RX FSM IDLE->START->DATA->PARITY->STOP->IDLE:
  - Falling edge in IDLE enters START.
  - At tick 7 (mid-bit) of START: line still 0 confirms the start bit; line 1 is a glitch and returns to IDLE.
  - Thereafter each bit is sampled at tick 15 after the previous sample, i.e. mid-bit.
  - Data bits are shifted in LSB first.
- RX completion, at the stop-bit sample:
  - LSR[3] = sampled stop bit.
  - LSR[2] set if the received parity is not even; a sticky error, cleared only by clear_flags.
  - LSR[1] set if LSR[0] is already 1 or fifo_full=1 at this moment.
  - If fifo_full=0: data_out <= byte and LSR[0] <= 1. If fifo_full=1: data_out is kept and LSR[0] is unchanged.
  - Bytes are delivered even with a framing error.
- clear_flags clears LSR[2:0] next clock and leaves data_out unchanged. When clear_flags coincides with a completion, the completion wins.
- Mid-frame reset aborts both FSMs immediately; tx returns high.
- TX and RX are fully independent; simultaneous operation is required.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: 8E1 frame (11 bit times) with a PARITY state; LSR[2] is active.
- Undefined: 8N1 frame (10 bit times); PARITY state is removed in both FSMs; LSR[2] is tied to 0.
- Both ends use the same setting.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - LSR bit-index constants LSR_DA=0, LSR_OE=1, LSR_PE=2, LSR_NFE=3;
  - DATA_BITS=8.
- One natural sub-module: uart_baud_gen (tick counter), instantiated once and shared by TX and RX.

Test Plan:
- Loopback tx->rx, 10 random bytes: for each, pulse tx_start, wait for tx_done_tick, then LSR[0]=1. Require data_out = sent byte, LSR[3]=1, LSR[2]=0, LSR[1]=0. Pulse clear_flags; require LSR[0]=0 with data_out retained.
- Send 8'hA5: bit period = 16*326 clocks ±1. tx shows start 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1. tx_done_tick is high for exactly 1 clock.
- Send two bytes without clear_flags: second completion sets LSR[1]=1 and data_out = second byte.
- Hold fifo_full=1 and send 8'h3C: LSR[1]=1, data_out unchanged, LSR[0] unchanged.
- Drive rx with a stop bit of 0 (byte 8'h55): LSR[3]=0 and data_out=8'h55. With UART_PARITY_EN, a wrong parity bit gives LSR[2]=1.
- Assert reset mid-frame: tx=1 and LSR=8'h08 immediately. A 4-clock low glitch on idle rx produces no reception.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core: FSM state encoding, LSR bit
// positions and the data width.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam int unsigned LSR_DA  = 0;
  localparam int unsigned LSR_OE  = 1;
  localparam int unsigned LSR_PE  = 2;
  localparam int unsigned LSR_NFE = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick generator; b_tick is a single-clock pulse each
// time the counter wraps to zero.
module uart_baud_gen #(
  parameter int unsigned TICK_DIV = 326
) (
  input  logic clock,
  input  logic reset,
  output logic b_tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      b_tick <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      b_tick <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
      b_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8-bit UART with a shared baud generator, transmitter and 16x
// oversampling receiver. Define UART_PARITY_EN for 8E1 framing (default 8N1).
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 tx_done_tick,
  output logic                 tx_busy,
  input  logic                 rx,
  input  logic                 fifo_full,
  input  logic                 clear_flags,
  output logic [DATA_BITS-1:0] data_out,
  output logic [7:0]           LSR,
  output logic                 b_tick
);

  localparam int unsigned TICK_DIV =
    (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  uart_baud_gen #(.TICK_DIV(TICK_DIV)) u_baud_gen (
    .clock  (clock),
    .reset  (reset),
    .b_tick (b_tick)
  );

  // ---------------------------------------------------------------- transmitter
  uart_state_e          tx_state_q, tx_state_d;
  logic [TICK_W-1:0]    tx_tick_q, tx_tick_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_d, tx_done_d, tx_busy_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q   <= IDLE;
      tx_tick_q    <= '0;
      tx_bit_q     <= '0;
      tx_shreg_q   <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_busy      <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_tick_q    <= tx_tick_d;
      tx_bit_q     <= tx_bit_d;
      tx_shreg_q   <= tx_shreg_d;
      tx           <= tx_d;
      tx_done_tick <= tx_done_d;
      tx_busy      <= tx_busy_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tx_par_q <= 1'b0;
    else        tx_par_q <= tx_par_d;
  end
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_d       = tx;
    tx_done_d  = 1'b0;
    tx_busy_d  = tx_busy;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      IDLE: begin
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        if (tx_start) begin
          tx_state_d = START;
          tx_tick_d  = '0;
          tx_shreg_d = data_in;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
`ifdef UART_PARITY_EN
          tx_par_d   = ^data_in;
`endif
        end
      end
      START: if (b_tick) begin
        if (tx_tick_q == LAST_TICK) begin
          tx_state_d = DATA;
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shreg_q[0];
        end else tx_tick_d = tx_tick_q + TICK_W'(1);
      end
      DATA: if (b_tick) begin
        if (tx_tick_q == LAST_TICK) begin
          tx_tick_d  = '0;
          tx_shreg_d = tx_shreg_q >> 1;
          if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_d = PARITY;
            tx_d       = tx_par_q;
`else
            tx_state_d = STOP;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
            tx_d     = tx_shreg_q[1];
          end
        end else tx_tick_d = tx_tick_q + TICK_W'(1);
      end
`ifdef UART_PARITY_EN
      PARITY: if (b_tick) begin
        if (tx_tick_q == LAST_TICK) begin
          tx_state_d = STOP;
          tx_tick_d  = '0;
          tx_d       = 1'b1;
        end else tx_tick_d = tx_tick_q + TICK_W'(1);
      end
`endif
      STOP: if (b_tick) begin
        if (tx_tick_q == LAST_TICK) begin
          tx_state_d = IDLE;
          tx_tick_d  = '0;
          tx_done_d  = 1'b1;
          tx_busy_d  = 1'b0;
        end else tx_tick_d = tx_tick_q + TICK_W'(1);
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------- receiver
  logic                 rx_meta, rx_sync, rx_prev;
  uart_state_e          rx_state_q, rx_state_d;
  logic [TICK_W-1:0]    rx_tick_q, rx_tick_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_BITS-1:0] data_out_d;
  logic                 da_q, da_d, oe_q, oe_d, nfe_q, nfe_d;
`ifdef UART_PARITY_EN
  logic                 pe_q, pe_d, rx_par_q, rx_par_d;
`endif

  // Synchronizer flops idle high so a reset never looks like a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state_q <= IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      data_out   <= '0;
      da_q       <= 1'b0;
      oe_q       <= 1'b0;
      nfe_q      <= 1'b1;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      data_out   <= data_out_d;
      da_q       <= da_d;
      oe_q       <= oe_d;
      nfe_q      <= nfe_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pe_q     <= 1'b0;
      rx_par_q <= 1'b0;
    end else begin
      pe_q     <= pe_d;
      rx_par_q <= rx_par_d;
    end
  end
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    data_out_d = data_out;
    da_d       = da_q;
    oe_d       = oe_q;
    nfe_d      = nfe_q;
`ifdef UART_PARITY_EN
    pe_d       = pe_q;
    rx_par_d   = rx_par_q;
`endif
    if (clear_flags) begin
      da_d = 1'b0;
      oe_d = 1'b0;
`ifdef UART_PARITY_EN
      pe_d = 1'b0;
`endif
    end
    case (rx_state_q)
      IDLE: if (rx_prev && !rx_sync) begin
        rx_state_d = START;
        rx_tick_d  = '0;
      end
      START: if (b_tick) begin
        if (rx_tick_q == MID_TICK) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? IDLE : DATA;
        end else rx_tick_d = rx_tick_q + TICK_W'(1);
      end
      DATA: if (b_tick) begin
        if (rx_tick_q == LAST_TICK) begin
          rx_tick_d  = '0;
          rx_shreg_d = {rx_sync, rx_shreg_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_d = PARITY;
`else
            rx_state_d = STOP;
`endif
          end else rx_bit_d = rx_bit_q + BIT_W'(1);
        end else rx_tick_d = rx_tick_q + TICK_W'(1);
      end
`ifdef UART_PARITY_EN
      PARITY: if (b_tick) begin
        if (rx_tick_q == LAST_TICK) begin
          rx_tick_d  = '0;
          rx_par_d   = rx_sync;
          rx_state_d = STOP;
        end else rx_tick_d = rx_tick_q + TICK_W'(1);
      end
`endif
      // Completion overrides a coincident clear_flags.
      STOP: if (b_tick) begin
        if (rx_tick_q == LAST_TICK) begin
          rx_tick_d  = '0;
          rx_state_d = IDLE;
          nfe_d      = rx_sync;
`ifdef UART_PARITY_EN
          if (^{rx_shreg_q, rx_par_q}) pe_d = 1'b1;
`endif
          if (da_q || fifo_full) oe_d = 1'b1;
          if (fifo_full) begin
            da_d = da_q;
          end else begin
            data_out_d = rx_shreg_q;
            da_d       = 1'b1;
          end
        end else rx_tick_d = rx_tick_q + TICK_W'(1);
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    LSR          = '0;
    LSR[LSR_DA]  = da_q;
    LSR[LSR_OE]  = oe_q;
    LSR[LSR_NFE] = nfe_q;
`ifdef UART_PARITY_EN
    LSR[LSR_PE]  = pe_q;
`else
    LSR[LSR_PE]  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: tx looped back to rx, plus a direct rx driver
// for framing, parity and glitch cases. Honours UART_PARITY_EN like the RTL.
module tb_uart_core;

  localparam int unsigned CLK_FREQ = 1228800;  // 8 clocks per baud tick
  localparam int TICK = 8;
  localparam int BIT  = 16 * TICK;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, tx_done_tick, tx_busy;
  logic       rx;
  logic       fifo_full = 1'b0;
  logic       clear_flags = 1'b0;
  logic [7:0] data_out, LSR;
  logic       b_tick;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;
  logic       drv_done = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [7:0] lsr;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] vec [10] = '{8'h3A, 8'hC5, 8'h00, 8'hFF, 8'h81,
                           8'h7E, 8'h12, 8'hED, 8'h69, 8'h96};

  assign rx = loop_en ? tx : rx_drv;

  always #5 clock = ~clock;

  uart_core #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (9600),
    .OVERSAMPLE (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_start     (tx_start),
    .data_in      (data_in),
    .tx           (tx),
    .tx_done_tick (tx_done_tick),
    .tx_busy      (tx_busy),
    .rx           (rx),
    .fifo_full    (fifo_full),
    .clear_flags  (clear_flags),
    .data_out     (data_out),
    .LSR          (LSR),
    .b_tick       (b_tick)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %02h required %02h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input string n, input logic [7:0] d, input logic [7:0] l);
    exp_t e;
    e.name = n;
    e.data = d;
    e.lsr  = l;
    sbq.push_back(e);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    data_in  = b;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    check("tx_busy", 8'(tx_busy), 8'h01);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!tx_done_tick && n < 20 * BIT) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!tx_done_tick) begin
      errors++;
      $display("FAIL %s_timeout: no tx_done_tick within %0d clocks", name, 20 * BIT);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic par, input logic stop);
    @(negedge clock);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      rx_drv = b[k];
      repeat (BIT) @(negedge clock);
    end
`ifdef UART_PARITY_EN
    rx_drv = par;
    repeat (BIT) @(negedge clock);
`else
    if (par) rx_drv = 1'b1;
`endif
    rx_drv = stop;
    repeat (BIT) @(negedge clock);
    rx_drv = 1'b1;
    @(posedge clock);
    drv_done = 1'b1;
    @(posedge clock);
    drv_done = 1'b0;
  endtask

  // Monitor: a completion is marked by tx_done_tick (loopback) or drv_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && (tx_done_tick || drv_done)) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: completion seen with no expected entry");
        end else begin
          e = sbq.pop_front();
          check({e.name, "_data"}, data_out, e.data);
          check({e.name, "_lsr"}, LSR, e.lsr);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] a5;
    a5 = 8'hA5;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx", 8'(tx), 8'h01);
    check("rst_done", 8'(tx_done_tick), 8'h00);
    check("rst_busy", 8'(tx_busy), 8'h00);
    check("rst_data", data_out, 8'h00);
    check("rst_lsr", LSR, 8'h08);
    check("rst_btick", 8'(b_tick), 8'h00);
    reset = 1'b1;

    // Baud tick spacing
    n = 0;
    while (!b_tick && n < 4 * TICK) begin @(negedge clock); n++; end
    n = 0;
    do begin @(negedge clock); n++; end while (!b_tick && n < 4 * TICK);
    check("btick_period", 8'(n), 8'(TICK));

    // Loopback of directed bytes
    for (int i = 0; i < 10; i++) begin
      push_exp("loop", vec[i], 8'h09);
      send_byte(vec[i]);
      wait_done("loop");
      pulse_clear();
      check("loop_clr_lsr", LSR, 8'h08);
      check("loop_clr_data", data_out, vec[i]);
    end

    // Waveform of 8'hA5
    push_exp("a5", 8'hA5, 8'h09);
    send_byte(a5);
    check("a5_start", 8'(tx), 8'h00);
    n = 0;
    while (tx == 1'b0 && n < 2 * BIT) begin @(negedge clock); n++; end
    check("a5_bit0", 8'(tx), 8'h01);
    n = 0;
    while (tx == 1'b1 && n < 2 * BIT) begin @(negedge clock); n++; end
    checks++;
    if (n < BIT - 1 || n > BIT + 1) begin
      errors++;
      $display("FAIL a5_bit_period: actual %0d clocks required %0d", n, BIT);
    end
    repeat (BIT / 2) @(negedge clock);
    check("a5_bit1", 8'(tx), 8'(a5[1]));
    for (int k = 2; k < 8; k++) begin
      repeat (BIT) @(negedge clock);
      check($sformatf("a5_bit%0d", k), 8'(tx), 8'(a5[k]));
    end
`ifdef UART_PARITY_EN
    repeat (BIT) @(negedge clock);
    check("a5_parity", 8'(tx), 8'h00);
`endif
    repeat (BIT) @(negedge clock);
    check("a5_stop", 8'(tx), 8'h01);
    wait_done("a5");
    @(negedge clock);
    check("a5_done_width", 8'(tx_done_tick), 8'h00);
    pulse_clear();
    check("a5_clr_lsr", LSR, 8'h08);

    // Two bytes without clear: overrun
    push_exp("ovr1", 8'h11, 8'h09);
    send_byte(8'h11);
    wait_done("ovr1");
    push_exp("ovr2", 8'h22, 8'h0B);
    send_byte(8'h22);
    wait_done("ovr2");
    pulse_clear();
    check("ovr_clr_lsr", LSR, 8'h08);
    check("ovr_clr_data", data_out, 8'h22);

    // FIFO full blocks delivery
    fifo_full = 1'b1;
    push_exp("full", 8'h22, 8'h0A);
    send_byte(8'h3C);
    wait_done("full");
    fifo_full = 1'b0;
    pulse_clear();
    check("full_clr_lsr", LSR, 8'h08);
    check("full_clr_data", data_out, 8'h22);

    // Short low glitch on an idle line
    loop_en = 1'b0;
    @(negedge clock);
    rx_drv = 1'b0;
    repeat (4) @(negedge clock);
    rx_drv = 1'b1;
    repeat (2 * BIT) @(negedge clock);
    check("glitch_lsr", LSR, 8'h08);
    check("glitch_data", data_out, 8'h22);

    // Stop bit of 0 still delivers the byte
    push_exp("frame", 8'h55, 8'h01);
    drive_frame(8'h55, 1'b0, 1'b0);
    pulse_clear();
    check("frame_clr_lsr", LSR, 8'h00);
    check("frame_clr_data", data_out, 8'h55);

`ifdef UART_PARITY_EN
    push_exp("parity", 8'h55, 8'h0D);
    drive_frame(8'h55, 1'b1, 1'b1);
    pulse_clear();
    check("parity_clr_lsr", LSR, 8'h08);
`endif

    // Reset in the middle of a frame
    loop_en = 1'b1;
    send_byte(8'h00);
    repeat (3 * BIT) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 8'(tx), 8'h01);
    check("mid_rst_lsr", LSR, 8'h08);
    check("mid_rst_busy", 8'(tx_busy), 8'h00);
    check("mid_rst_data", data_out, 8'h00);
    @(negedge clock);
    reset = 1'b1;

    // Recovery after reset
    push_exp("post", 8'h5A, 8'h09);
    send_byte(8'h5A);
    wait_done("post");
    pulse_clear();
    check("post_clr_lsr", LSR, 8'h08);
    check("post_clr_data", data_out, 8'h5A);

    repeat (4) @(negedge clock);
    check("sb_drained", 8'(sbq.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
